// File: rtl/riscv_pkg.sv
// Shared core types and constants.
// Used by the fetch sequencer and its skid buffer.
package riscv_pkg;

   typedef enum logic [1:0] {
      FS_BOOT,
      FS_REQ,
      FS_HOLD,
      FS_DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_ent_t;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] PC_INC  = 32'd4;
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register for a fetched word that
// arrives while the IF/ID buffer is still occupied.
module fetch_skid
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       res,
   input  logic       load,
   input  logic       drain,
   input  logic       clear,
   input  fetch_ent_t din,
   output fetch_ent_t dout,
   output logic       valid
);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         dout  <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         dout  <= '0;
         valid <= 1'b0;
      end else if (drain) begin
         valid <= 1'b0;
      end else if (load) begin
         dout  <= din;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC write port, imem
// handshake and the IF/ID instruction buffer.
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        res,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_in,
   output logic        pc_write,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_id_flush
);

   fetch_state_e state, state_n;
   logic [31:0]  pend_q;
   logic [31:0]  tgt;
   logic         free;
   logic         kill;
   logic         ld_buf;
   logic         pend_ld;
   logic         sk_load;
   logic         sk_drain;
   logic         sk_clear;
   logic         skid_v;
   fetch_ent_t   fetch_ent;
   fetch_ent_t   skid_q;
   fetch_ent_t   buf_d;

   assign tgt       = redirect_target & PC_MASK;
   assign free      = !if_valid || !stall;
   assign imem_addr = pc_cur;
   assign imem_req  = (state == FS_REQ) ||
                      (state == FS_DRAIN);
   assign fetch_ent = '{instr: imem_rdata, pc: pc_cur};

   fetch_skid u_skid (
      .clk   (clk),
      .res   (res),
      .load  (sk_load),
      .drain (sk_drain),
      .clear (sk_clear),
      .din   (fetch_ent),
      .dout  (skid_q),
      .valid (skid_v)
   );

   always_comb begin
      state_n     = state;
      pc_in       = pc_cur;
      pc_write    = 1'b0;
      if_id_flush = 1'b0;
      kill        = 1'b0;
      ld_buf      = 1'b0;
      buf_d       = fetch_ent;
      pend_ld     = 1'b0;
      sk_load     = 1'b0;
      sk_drain    = 1'b0;
      sk_clear    = 1'b0;
      unique case (state)
         FS_BOOT: begin
            // Held off while reset is asserted.
            pc_in    = RESET_VEC;
            pc_write = res;
            state_n  = FS_REQ;
         end
         FS_REQ: begin
            unique case (1'b1)
               imem_ack && redirect: begin
                  pc_in       = tgt;
                  pc_write    = 1'b1;
                  if_id_flush = 1'b1;
                  kill        = 1'b1;
               end
               imem_ack && !redirect && free: begin
                  ld_buf   = 1'b1;
                  pc_in    = pc_cur + PC_INC;
                  pc_write = 1'b1;
               end
               imem_ack && !redirect && !free: begin
                  sk_load = 1'b1;
                  state_n = FS_HOLD;
               end
               !imem_ack && redirect: begin
                  pend_ld     = 1'b1;
                  if_id_flush = 1'b1;
                  kill        = 1'b1;
                  state_n     = FS_DRAIN;
               end
               default: ;
            endcase
         end
         FS_HOLD: begin
            if (redirect) begin
               pc_in       = tgt;
               pc_write    = 1'b1;
               if_id_flush = 1'b1;
               kill        = 1'b1;
               sk_clear    = 1'b1;
               state_n     = FS_REQ;
            end else if (skid_v && free) begin
               ld_buf   = 1'b1;
               buf_d    = skid_q;
               pc_in    = skid_q.pc + PC_INC;
               pc_write = 1'b1;
               sk_drain = 1'b1;
               state_n  = FS_REQ;
            end
         end
         FS_DRAIN: begin
            if (redirect) begin
               pend_ld     = 1'b1;
               if_id_flush = 1'b1;
               kill        = 1'b1;
            end
            // A redirect coinciding with ack is the latest target.
            if (imem_ack) begin
               pc_in    = redirect ? tgt : pend_q;
               pc_write = 1'b1;
               state_n  = FS_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state  <= FS_BOOT;
         pend_q <= '0;
      end else begin
         state <= state_n;
         if (pend_ld)
            pend_q <= tgt;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         if_valid <= 1'b0;
         if_instr <= NOP;
         if_pc    <= '0;
      end else if (kill) begin
         if_valid <= 1'b0;
      end else if (ld_buf) begin
         if_valid <= 1'b1;
         if_instr <= buf_d.instr;
         if_pc    <= buf_d.pc;
      end else if (if_valid && !stall) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed table, corner sequences
// and a random run against an instruction-stream model.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic [31:0] pc_cur;
   logic [31:0] pc_in;
   logic        pc_write;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_id_flush;

   logic        pc_ovr = 1'b0;
   logic [31:0] pc_ovr_val = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_VEC(32'h0000_0100)) dut (
      .clk             (clk),
      .res             (res),
      .pc_cur          (pc_cur),
      .pc_in           (pc_in),
      .pc_write        (pc_write),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_id_flush     (if_id_flush)
   );

   // External PC register written through the DUT port.
   always @(posedge clk or negedge res) begin
      if (!res)
         pc_cur <= '0;
      else if (pc_ovr)
         pc_cur <= pc_ovr_val;
      else if (pc_write)
         pc_cur <= pc_in;
   end

   function automatic logic [31:0] mem_word(
      input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req"},   {31'd0, imem_req}, 0);
      chk({tag, "_pcw"},   {31'd0, pc_write}, 0);
      chk({tag, "_flush"}, {31'd0, if_id_flush}, 0);
      chk({tag, "_valid"}, {31'd0, if_valid}, 0);
      chk({tag, "_instr"}, if_instr, 32'h0000_0013);
      chk({tag, "_ifpc"},  if_pc, 32'h0);
   endtask

   // Leaves the bench at a negedge in the BOOT cycle.
   task automatic do_reset();
      res      = 1'b0;
      stall    = 1'b0;
      redirect = 1'b0;
      imem_ack = 1'b0;
      pc_ovr   = 1'b0;
      @(negedge clk);
      #1;
      reset_checks("rst");
      @(negedge clk);
      res = 1'b1;
   endtask

   typedef struct {
      bit          stall;
      bit          ack;
      bit          redir;
      logic [31:0] tgt;
      bit          req;
      bit          pcw;
      bit          flush;
      bit          valid;
      logic [31:0] addr;
      logic [31:0] pcin;
      logic [31:0] ifpc;
   } vec_t;

   vec_t vt[19];

   initial begin
      int          lat;
      bit          outst;
      bit          acked;
      logic [31:0] saddr;
      logic [31:0] exp_pc;
      logic [31:0] held_pc;
      logic [31:0] held_instr;
      bit          prev_kill;
      bit          prev_hold;
      int          delivered;

      //      st ack rd tgt        req pcw fl v addr   pcin   ifpc
      vt[0]  = '{0,1,0,32'h0,    0,1,0,0,32'h0,  32'h100,32'h0};
      vt[1]  = '{0,1,0,32'h0,    1,1,0,0,32'h100,32'h104,32'h0};
      vt[2]  = '{0,1,0,32'h0,    1,1,0,1,32'h104,32'h108,32'h100};
      vt[3]  = '{0,1,0,32'h0,    1,1,0,1,32'h108,32'h10c,32'h104};
      vt[4]  = '{1,1,0,32'h0,    1,0,0,1,32'h10c,32'h0,  32'h108};
      vt[5]  = '{1,1,0,32'h0,    0,0,0,1,32'h0,  32'h0,  32'h108};
      vt[6]  = '{0,1,0,32'h0,    0,1,0,1,32'h0,  32'h110,32'h108};
      vt[7]  = '{0,1,0,32'h0,    1,1,0,1,32'h110,32'h114,32'h10c};
      vt[8]  = '{0,1,1,32'h203,  1,1,1,1,32'h114,32'h200,32'h110};
      vt[9]  = '{0,1,0,32'h0,    1,1,0,0,32'h200,32'h204,32'h0};
      vt[10] = '{0,0,0,32'h0,    1,0,0,1,32'h204,32'h0,  32'h200};
      vt[11] = '{0,0,1,32'h300,  1,0,1,0,32'h204,32'h0,  32'h0};
      vt[12] = '{0,0,0,32'h0,    1,0,0,0,32'h204,32'h0,  32'h0};
      vt[13] = '{0,1,0,32'h0,    1,1,0,0,32'h204,32'h300,32'h0};
      vt[14] = '{0,1,0,32'h0,    1,1,0,0,32'h300,32'h304,32'h0};
      vt[15] = '{0,1,0,32'h0,    1,1,0,1,32'h304,32'h308,32'h300};
      vt[16] = '{1,0,0,32'h0,    1,0,0,1,32'h308,32'h0,  32'h304};
      vt[17] = '{0,1,0,32'h0,    1,1,0,1,32'h308,32'h30c,32'h304};
      vt[18] = '{0,0,0,32'h0,    1,0,0,1,32'h30c,32'h0,  32'h308};

      do_reset();
      for (int i = 0; i < 19; i++) begin
         stall           = vt[i].stall;
         imem_ack        = vt[i].ack;
         redirect        = vt[i].redir;
         redirect_target = vt[i].tgt;
         imem_rdata      = mem_word(imem_addr);
         #1;
         chk($sformatf("t%0d_req", i),
             {31'd0, imem_req}, {31'd0, vt[i].req});
         chk($sformatf("t%0d_pcw", i),
             {31'd0, pc_write}, {31'd0, vt[i].pcw});
         chk($sformatf("t%0d_flush", i),
             {31'd0, if_id_flush}, {31'd0, vt[i].flush});
         chk($sformatf("t%0d_valid", i),
             {31'd0, if_valid}, {31'd0, vt[i].valid});
         if (vt[i].req)
            chk($sformatf("t%0d_addr", i),
                imem_addr, vt[i].addr);
         if (vt[i].pcw)
            chk($sformatf("t%0d_pcin", i),
                pc_in, vt[i].pcin);
         if (vt[i].valid) begin
            chk($sformatf("t%0d_ifpc", i),
                if_pc, vt[i].ifpc);
            chk($sformatf("t%0d_instr", i),
                if_instr, mem_word(vt[i].ifpc));
         end
         @(negedge clk);
      end
      redirect = 1'b0;

      // Redirect beats stall while the skid is occupied.
      do_reset();
      imem_ack = 1'b0;
      #1;
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      #1;
      @(negedge clk);
      stall      = 1'b1;
      imem_rdata = mem_word(imem_addr);
      #1;
      chk("b_skid_pcw", {31'd0, pc_write}, 0);
      @(negedge clk);
      redirect        = 1'b1;
      redirect_target = 32'h402;
      #1;
      chk("b_hold_req", {31'd0, imem_req}, 0);
      chk("b_flush", {31'd0, if_id_flush}, 1);
      chk("b_pcw", {31'd0, pc_write}, 1);
      chk("b_pcin", pc_in, 32'h400);
      @(negedge clk);
      redirect   = 1'b0;
      stall      = 1'b0;
      imem_rdata = mem_word(imem_addr);
      #1;
      chk("b_killed", {31'd0, if_valid}, 0);
      chk("b_req", {31'd0, imem_req}, 1);
      chk("b_addr", imem_addr, 32'h400);
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      chk("b_valid", {31'd0, if_valid}, 1);
      chk("b_ifpc", if_pc, 32'h400);
      chk("b_instr", if_instr, mem_word(32'h400));

      // PC wrap, then reset asserted while draining.
      do_reset();
      imem_ack   = 1'b0;
      pc_ovr     = 1'b1;
      pc_ovr_val = 32'hFFFF_FFFC;
      #1;
      @(negedge clk);
      pc_ovr     = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      #1;
      chk("w_addr", imem_addr, 32'hFFFF_FFFC);
      chk("w_pcw", {31'd0, pc_write}, 1);
      chk("w_pcin", pc_in, 32'h0);
      @(negedge clk);
      imem_ack        = 1'b0;
      redirect        = 1'b1;
      redirect_target = 32'h500;
      #1;
      chk("w_ifpc", if_pc, 32'hFFFF_FFFC);
      chk("w_addr0", imem_addr, 32'h0);
      chk("w_flush", {31'd0, if_id_flush}, 1);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("d_req", {31'd0, imem_req}, 1);
      chk("d_flush", {31'd0, if_id_flush}, 0);
      res = 1'b0;
      #1;
      reset_checks("d_rst");
      @(negedge clk);
      res = 1'b1;
      #1;
      chk("d_boot_pcw", {31'd0, pc_write}, 1);
      chk("d_boot_pcin", pc_in, 32'h100);
      chk("d_boot_req", {31'd0, imem_req}, 0);

      // Random run against the instruction-stream model.
      do_reset();
      outst     = 0;
      acked     = 0;
      lat       = 0;
      saddr     = '0;
      exp_pc    = 32'h100;
      held_pc   = '0;
      held_instr = '0;
      prev_kill = 0;
      prev_hold = 0;
      delivered = 0;
      for (int c = 0; c < 4000; c++) begin
         if (imem_req) begin
            if (!outst || acked) begin
               outst = 1;
               acked = 0;
               lat   = $urandom_range(0, 3);
               saddr = imem_addr;
            end else begin
               chk("addr_stable", imem_addr, saddr);
            end
            if (lat == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_word(imem_addr);
               acked      = 1;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = $urandom;
               lat--;
            end
         end else begin
            outst      = 0;
            acked      = 0;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
         end
         stall = ($urandom_range(0, 3) == 0);
         redirect = (c >= 1) &&
                    ($urandom_range(0, 11) == 0);
         redirect_target = $urandom & 32'h0000_FFFF;
         #1;
         if (prev_kill)
            chk("kill_valid", {31'd0, if_valid}, 0);
         if (prev_hold) begin
            chk("hold_valid", {31'd0, if_valid}, 1);
            chk("hold_pc", if_pc, held_pc);
            chk("hold_instr", if_instr, held_instr);
         end
         chk("flush", {31'd0, if_id_flush},
             {31'd0, redirect});
         if (if_valid && !redirect) begin
            chk("instr", if_instr, mem_word(if_pc));
            if (!stall) begin
               chk("stream_pc", if_pc, exp_pc);
               exp_pc = exp_pc + 32'd4;
               delivered++;
            end
         end
         if (redirect)
            exp_pc = redirect_target & 32'hFFFF_FFFC;
         prev_kill  = redirect;
         prev_hold  = if_valid && stall && !redirect;
         held_pc    = if_pc;
         held_instr = if_instr;
         @(negedge clk);
      end
      chk("progress", {31'd0, delivered > 300}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
